piece_driver: RTL and testbench

PIECE_DRIVER -- requirements
Module: piece_driver

---
 rtl/detris_pkg.sv | 21 ++
 rtl/piece_driver_gravity_timer.sv | 31 +++
 rtl/piece_driver.sv | 145 ++++++++++++++
 tb/tb_piece_driver.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/detris_pkg.sv
// Shared types and board geometry for the falling-piece game blocks.
package detris_pkg;

    localparam int unsigned BOARD_W               = 10;
    localparam int unsigned BOARD_H               = 20;
    localparam int unsigned SPAWN_X_DEFAULT       = 4;
    localparam int unsigned GRAVITY_TICKS_DEFAULT = 25000000;

    typedef logic [2:0] piece_id_t;

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        SETTLE,
        FALL,
        HARD,
        LOCK,
        OVER
    } state_t;

endpackage

// File: rtl/piece_driver_gravity_timer.sv
// Free-running gravity divider: pulses tick on the last count of each period while enabled.
module gravity_timer
    import detris_pkg::*;
#(
    parameter int unsigned GRAVITY_TICKS = GRAVITY_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int unsigned   CW       = (GRAVITY_TICKS > 1) ? $clog2(GRAVITY_TICKS) : 1;
    localparam logic [CW-1:0] TERMINAL = CW'(GRAVITY_TICKS - 1);

    logic [CW-1:0] count;
    logic          at_end;

    assign at_end = (count == TERMINAL);
    assign tick   = enable && at_end;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= at_end ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/piece_driver.sv
// Active-piece controller: spawns, moves, rotates, drops and locks one tetromino at a time.
module piece_driver
    import detris_pkg::*;
#(
    parameter int unsigned GRAVITY_TICKS = GRAVITY_TICKS_DEFAULT,
    parameter int unsigned SPAWN_X       = SPAWN_X_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  piece_id_t  next_piece,
    output logic       take_next,
    input  logic       move_left,
    input  logic       move_right,
    input  logic       rotate,
    input  logic       drop,
    input  logic       blocked_left,
    input  logic       blocked_right,
    input  logic       blocked_down,
    input  logic       blocked_rot,
    input  logic       spawn_blocked,
    output piece_id_t  piece_id,
    output logic [3:0] piece_x,
    output logic [4:0] piece_y,
    output logic [1:0] piece_rot,
    output logic       piece_active,
    output logic       lock_pulse,
    output logic       game_over
);

    localparam logic [3:0] X_MAX   = 4'(BOARD_W - 1);
    localparam logic [4:0] Y_MAX   = 5'(BOARD_H - 1);
    localparam logic [3:0] X_SPAWN = 4'(SPAWN_X);

    state_t     state_q, state_d;
    piece_id_t  id_d;
    logic [3:0] x_d;
    logic [4:0] y_d;
    logic [1:0] rot_d;
    logic       moved, hold_q;
    logic       tick, timer_en, timer_clear;

    assign timer_en    = (state_q == FALL);
    assign timer_clear = (state_q == SPAWN);

    gravity_timer #(
        .GRAVITY_TICKS(GRAVITY_TICKS)
    ) u_gravity (
        .clk   (clk),
        .reset (reset),
        .enable(timer_en),
        .clear (timer_clear),
        .tick  (tick)
    );

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d = state_q;
        id_d    = piece_id;
        x_d     = piece_x;
        y_d     = piece_y;
        rot_d   = piece_rot;
        moved   = 1'b0;
        case (state_q)
            IDLE:   if (start) state_d = SPAWN;
            SPAWN: begin
                id_d    = next_piece;
                x_d     = X_SPAWN;
                y_d     = '0;
                rot_d   = '0;
                state_d = SETTLE;
            end
            SETTLE: state_d = spawn_blocked ? OVER : FALL;
            FALL: begin
                // hold_q marks the cycle after a move, when blocked_* still describe the old
                // position; a gravity tick landing there or alongside a user pulse is discarded.
                if (!hold_q) begin
                    if (drop) begin
                        state_d = HARD;
                    end else if (rotate) begin
                        if (!blocked_rot) begin
                            rot_d = piece_rot + 2'd1;
                            moved = 1'b1;
                        end
                    end else if (move_left) begin
                        if (!blocked_left && piece_x != 4'd0) begin
                            x_d   = piece_x - 4'd1;
                            moved = 1'b1;
                        end
                    end else if (move_right) begin
                        if (!blocked_right && piece_x < X_MAX) begin
                            x_d   = piece_x + 4'd1;
                            moved = 1'b1;
                        end
                    end else if (tick) begin
                        if (!blocked_down && piece_y < Y_MAX) begin
                            y_d   = piece_y + 5'd1;
                            moved = 1'b1;
                        end else begin
                            state_d = LOCK;
                        end
                    end
                end
            end
            HARD: begin
                if (!hold_q) begin
                    if (!blocked_down && piece_y < Y_MAX) begin
                        y_d   = piece_y + 5'd1;
                        moved = 1'b1;
                    end else begin
                        state_d = LOCK;
                    end
                end
            end
            LOCK:    state_d = SPAWN;
            OVER:    state_d = OVER;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            piece_id  <= '0;
            piece_x   <= '0;
            piece_y   <= '0;
            piece_rot <= '0;
            hold_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            piece_id  <= id_d;
            piece_x   <= x_d;
            piece_y   <= y_d;
            piece_rot <= rot_d;
            hold_q    <= moved;
        end
    end

    assign take_next    = (state_q == SPAWN);
    assign lock_pulse   = (state_q == LOCK);
    assign game_over    = (state_q == OVER);
    assign piece_active = (state_q == SETTLE) || (state_q == FALL) || (state_q == HARD);

endmodule

// File: tb/tb_piece_driver.sv
// Scoreboard bench for piece_driver: a game-rule model predicts every cycle, a monitor compares.
module tb_piece_driver;

    localparam int GT = 4;

    logic       clk = 1'b0;
    logic       reset, start, take_next;
    logic [2:0] next_piece, piece_id;
    logic       move_left, move_right, rotate, drop;
    logic       blocked_left, blocked_right, blocked_down, blocked_rot, spawn_blocked;
    logic [3:0] piece_x;
    logic [4:0] piece_y;
    logic [1:0] piece_rot;
    logic       piece_active, lock_pulse, game_over;

    always #5 clk = ~clk;

    piece_driver #(
        .GRAVITY_TICKS(GT),
        .SPAWN_X      (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .next_piece   (next_piece),
        .take_next    (take_next),
        .move_left    (move_left),
        .move_right   (move_right),
        .rotate       (rotate),
        .drop         (drop),
        .blocked_left (blocked_left),
        .blocked_right(blocked_right),
        .blocked_down (blocked_down),
        .blocked_rot  (blocked_rot),
        .spawn_blocked(spawn_blocked),
        .piece_id     (piece_id),
        .piece_x      (piece_x),
        .piece_y      (piece_y),
        .piece_rot    (piece_rot),
        .piece_active (piece_active),
        .lock_pulse   (lock_pulse),
        .game_over    (game_over)
    );

    typedef struct packed {
        logic       reset, start, left, right, rot, drop, bl, br, bd, brot, sb;
        logic [2:0] next;
    } stim_t;

    typedef struct packed {
        logic [2:0] id;
        logic [3:0] x;
        logic [4:0] y;
        logic [1:0] rot;
        logic       active, take, lock, over;
    } obs_t;

    typedef struct {
        obs_t o;
        int   tag;
    } exp_t;

    typedef enum int { MD_IDLE, MD_SPAWN, MD_SETTLE, MD_FALL, MD_HARD, MD_LOCK, MD_OVER } mode_t;

    exp_t  expq[$];
    mode_t m_mode = MD_IDLE;
    int    m_x = 0, m_y = 0, m_rot = 0, m_id = 0, m_fall = 0;
    bit    m_fresh = 1'b0;
    int    n_tests = 0, n_fail = 0, cur_tag = 0;
    stim_t base;

    function automatic string tag_name(input int t);
        case (t)
            0:       return "reset_idle";
            1:       return "spawn";
            2:       return "free_fall";
            3:       return "drop_vs_left";
            4:       return "edges_rotate";
            5:       return "spawn_blocked";
            6:       return "reset_in_hard";
            default: return "random";
        endcase
    endfunction

    // Game rules applied to one clock edge with the inputs sampled there.
    task automatic model_step(input stim_t s);
        int ox, oy, orot;
        bit grav;
        ox = m_x; oy = m_y; orot = m_rot;
        if (s.reset) begin
            m_mode = MD_IDLE; m_x = 0; m_y = 0; m_rot = 0; m_id = 0; m_fall = 0; m_fresh = 1'b0;
            return;
        end
        case (m_mode)
            MD_IDLE:   if (s.start) m_mode = MD_SPAWN;
            MD_SPAWN: begin
                m_id = int'(s.next); m_x = 4; m_y = 0; m_rot = 0; m_fall = 0; m_mode = MD_SETTLE;
            end
            MD_SETTLE: m_mode = s.sb ? MD_OVER : MD_FALL;
            MD_FALL: begin
                grav = (m_fall % GT) == GT - 1;
                m_fall++;
                if (!m_fresh) begin
                    if (s.drop) m_mode = MD_HARD;
                    else if (s.rot) begin
                        if (!s.brot) m_rot = (m_rot + 1) % 4;
                    end else if (s.left) begin
                        if (!s.bl && m_x > 0) m_x--;
                    end else if (s.right) begin
                        if (!s.br && m_x < 9) m_x++;
                    end else if (grav) begin
                        if (!s.bd && m_y < 19) m_y++;
                        else m_mode = MD_LOCK;
                    end
                end
            end
            MD_HARD: if (!m_fresh) begin
                if (!s.bd && m_y < 19) m_y++;
                else m_mode = MD_LOCK;
            end
            MD_LOCK:   m_mode = MD_SPAWN;
            default:   m_mode = m_mode;
        endcase
        m_fresh = (m_mode == MD_FALL || m_mode == MD_HARD) &&
                  (ox != m_x || oy != m_y || orot != m_rot);
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        reset = s.reset; start = s.start; next_piece = s.next;
        move_left = s.left; move_right = s.right; rotate = s.rot; drop = s.drop;
        blocked_left = s.bl; blocked_right = s.br; blocked_down = s.bd;
        blocked_rot = s.brot; spawn_blocked = s.sb;
        model_step(s);
        e.o.id     = 3'(m_id);
        e.o.x      = 4'(m_x);
        e.o.y      = 5'(m_y);
        e.o.rot    = 2'(m_rot);
        e.o.active = (m_mode == MD_SETTLE || m_mode == MD_FALL || m_mode == MD_HARD);
        e.o.take   = (m_mode == MD_SPAWN);
        e.o.lock   = (m_mode == MD_LOCK);
        e.o.over   = (m_mode == MD_OVER);
        e.tag      = cur_tag;
        expq.push_back(e);
        @(negedge clk);
    endtask

    task automatic timeout(input string what);
        n_tests++;
        n_fail++;
        $display("FAIL timeout_%s: target not reached, got still waiting, expected reached", what);
    endtask

    task automatic wait_ready(input int limit);
        for (int i = 0; i < limit && !(m_mode == MD_FALL && !m_fresh); i++) step(base);
        if (!(m_mode == MD_FALL && !m_fresh)) timeout(tag_name(cur_tag));
    endtask

    task automatic wait_mode(input mode_t target, input int limit);
        for (int i = 0; i < limit && m_mode != target; i++) step(base);
        if (m_mode != target) timeout(tag_name(cur_tag));
    endtask

    task automatic pulse_ready(input stim_t p);
        wait_ready(20);
        step(stim_t'(base | p));
    endtask

    // Monitor: one expected snapshot per clock, checked 1 ns after the edge it describes.
    initial begin
        exp_t e;
        obs_t act;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e   = expq.pop_front();
                act = {piece_id, piece_x, piece_y, piece_rot, piece_active, take_next, lock_pulse, game_over};
                n_tests++;
                if (act !== e.o) begin
                    n_fail++;
                    $display("FAIL %s @%0t: got id=%0d x=%0d y=%0d rot=%0d act=%b take=%b lock=%b over=%b, expected id=%0d x=%0d y=%0d rot=%0d act=%b take=%b lock=%b over=%b",
                             tag_name(e.tag), $time, act.id, act.x, act.y, act.rot, act.active, act.take,
                             act.lock, act.over, e.o.id, e.o.x, e.o.y, e.o.rot, e.o.active, e.o.take,
                             e.o.lock, e.o.over);
                end
            end
        end
    end

    initial begin
        stim_t s, p;
        base = '0;
        {reset, start, move_left, move_right, rotate, drop} = 6'b100000;
        {blocked_left, blocked_right, blocked_down, blocked_rot, spawn_blocked} = '0;
        next_piece = '0;
        @(negedge clk);

        cur_tag = 0;
        s = base; s.reset = 1'b1;
        step(s); step(s);
        s = base; s.left = 1'b1; s.right = 1'b1; s.drop = 1'b1; s.rot = 1'b1;
        step(s); step(base);

        cur_tag = 1;
        base.next = 3'd3;
        s = base; s.start = 1'b1;
        step(s); step(base); step(base);

        cur_tag = 2;
        wait_mode(MD_LOCK, 200);
        base.next = 3'd6;
        step(base); step(base); step(base);

        cur_tag = 3;
        for (int i = 0; i < 100 && !(m_mode == MD_FALL && !m_fresh && m_y == 5); i++) step(base);
        if (!(m_mode == MD_FALL && !m_fresh && m_y == 5)) timeout("drop_at_y5");
        s = base; s.drop = 1'b1; s.left = 1'b1;
        step(s);
        wait_mode(MD_LOCK, 60);
        base.next = 3'd1;

        cur_tag = 4;
        p = '0; p.left = 1'b1;
        for (int i = 0; i < 5; i++) pulse_ready(p);
        p = '0; p.rot = 1'b1;
        for (int i = 0; i < 4; i++) pulse_ready(p);
        base.brot = 1'b1;
        for (int i = 0; i < 2; i++) pulse_ready(p);
        base.brot = 1'b0;
        p = '0; p.right = 1'b1;
        for (int i = 0; i < 11; i++) pulse_ready(p);
        base.br = 1'b1;
        p = '0; p.left = 1'b1;
        pulse_ready(p);
        base.br = 1'b0;
        base.bl = 1'b1;
        pulse_ready(p);
        base.bl = 1'b0;

        cur_tag = 5;
        s = base; s.reset = 1'b1;
        step(s);
        base.sb = 1'b1;
        s = base; s.start = 1'b1;
        step(s); step(base); step(base); step(base);
        step(s); step(base); step(s);
        base.sb = 1'b0;
        s = base; s.reset = 1'b1;
        step(s); step(base);

        cur_tag = 6;
        s = base; s.start = 1'b1;
        step(s);
        wait_ready(10);
        s = base; s.drop = 1'b1;
        step(s);
        for (int i = 0; i < 40 && !(m_mode == MD_HARD && m_y == 10); i++) step(base);
        if (!(m_mode == MD_HARD && m_y == 10)) timeout("hard_y10");
        s = base; s.reset = 1'b1;
        step(s); step(base); step(base);

        cur_tag = 7;
        for (int i = 0; i < 3000; i++) begin
            s.reset = ($urandom_range(0, 149) == 0);
            s.start = ($urandom_range(0, 7) == 0);
            s.left  = ($urandom_range(0, 3) == 0);
            s.right = ($urandom_range(0, 3) == 0);
            s.rot   = ($urandom_range(0, 5) == 0);
            s.drop  = ($urandom_range(0, 29) == 0);
            s.bl    = ($urandom_range(0, 3) == 0);
            s.br    = ($urandom_range(0, 3) == 0);
            s.bd    = ($urandom_range(0, 7) == 0);
            s.brot  = ($urandom_range(0, 3) == 0);
            s.sb    = ($urandom_range(0, 7) == 0);
            s.next  = 3'($urandom_range(0, 7));
            step(s);
        end
        step(base);

        repeat (3) @(negedge clk);
        if (expq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending snapshots, expected 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
